// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode map, fetch FSM states
// and the control-flow predecode helper.
package cpu_pkg;

   localparam int INSTR_W = 19;
   localparam int ADDR_W  = 16;
   localparam int OPC_W   = 5;

   typedef enum logic [OPC_W-1:0] {
      ADD  = 5'b00000,
      SUB  = 5'b00001,
      ANL  = 5'b00010,
      ORL  = 5'b00011,
      XRL  = 5'b00100,
      SHL  = 5'b00101,
      SHR  = 5'b00110,
      LDI  = 5'b00111,
      LD   = 5'b01000,
      ST   = 5'b01001,
      JMP  = 5'b01010,
      BEQ  = 5'b01011,
      BNE  = 5'b01100,
      CALL = 5'b01101,
      RET  = 5'b01110,
      PUSH = 5'b01111,
      POP  = 5'b10000,
      MOV  = 5'b10001,
      INCC = 5'b10010,
      DECC = 5'b10011
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FLUSH = 2'd2
   } fetch_state_t;

   function automatic logic is_ctrl(input opcode_t op);
      return (op >= JMP) && (op <= RET);
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: prefetch buffer, power-of-two DEPTH,
// synchronous reset and clear, combinational head read.
module ifetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 35
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          full;
   logic          do_pop;

   assign empty  = (count == '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign do_pop = pop && !empty;
   assign rdata  = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (do_pop)
            rptr <= rptr + 1'b1;
         if (push && !do_pop)
            count <= count + 1'b1;
         else if (!push && do_pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= wdata;
   end

   // credit gating upstream must make this unreachable
   always_ff @(posedge clk) begin
      if (!reset && !clear)
         assert (!(push && full));
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-gated prefetcher with redirect flush.
// Optional IFETCH_PREDECODE_EN stores opcode/is_ctrl per entry.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [18:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [18:0] instr,
   output logic [15:0] instr_pc,
   output logic [4:0]  instr_opcode,
   output logic        instr_is_ctrl
);

   localparam int CW = $clog2(DEPTH) + 1;
`ifdef IFETCH_PREDECODE_EN
   localparam int W = ADDR_W + INSTR_W + OPC_W + 1;
`else
   localparam int W = ADDR_W + INSTR_W;
`endif

   fetch_state_t      state;
   fetch_state_t      state_nx;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] rsp_pc;
   logic              inflight;
   logic              stale;
   logic              credit;
   logic              push;
   logic              pop;
   logic              empty;
   logic [CW-1:0]     count;
   logic [W-1:0]      wdata;
   logic [W-1:0]      rdata;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (redirect_valid) begin
         state_nx = S_FLUSH;
      end else begin
         unique case (state)
            S_IDLE:  state_nx = fetch_en ? S_FETCH : S_IDLE;
            S_FETCH: state_nx = fetch_en ? S_FETCH : S_IDLE;
            S_FLUSH: state_nx = fetch_en ? S_FETCH : S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // buffered plus outstanding words must fit the buffer
   assign credit = ({1'b0, count} + {{CW{1'b0}}, inflight})
                 < (CW+1)'(DEPTH);

   always_comb begin
      imem_req = 1'b0;
      if (!reset && state == S_FETCH && fetch_en && credit)
         imem_req = 1'b1;
   end

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         rsp_pc   <= '0;
         inflight <= 1'b0;
         stale    <= 1'b0;
      end else begin
         rsp_pc   <= pc;
         inflight <= imem_req;
         stale    <= redirect_valid && imem_req;
         if (redirect_valid)
            pc <= redirect_pc;
         else if (imem_req)
            pc <= pc + 16'd1;
      end
   end

   assign push = imem_rvalid && inflight && !stale;
   assign pop  = instr_valid && instr_ready;

`ifdef IFETCH_PREDECODE_EN
   logic [OPC_W-1:0] rsp_opc;
   assign rsp_opc = imem_rdata[INSTR_W-1 -: OPC_W];
   assign wdata = {rsp_opc, is_ctrl(opcode_t'(rsp_opc)),
                   rsp_pc, imem_rdata};
`else
   assign wdata = {rsp_pc, imem_rdata};
`endif

   ifetch_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (redirect_valid),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .count (count),
      .empty (empty)
   );

   assign instr_valid = !empty;
   assign instr    = instr_valid ? rdata[INSTR_W-1:0] : '0;
   assign instr_pc = instr_valid ? rdata[INSTR_W +: ADDR_W] : '0;

`ifdef IFETCH_PREDECODE_EN
   assign instr_opcode  = instr_valid ? rdata[W-1 -: OPC_W] : '0;
   assign instr_is_ctrl = instr_valid ? rdata[W-OPC_W-1] : 1'b0;
`else
   assign instr_opcode  = '0;
   assign instr_is_ctrl = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed phases plus random traffic,
// scoreboard of expected fetch addresses per restart point.
module tb_instr_fetch;

   localparam logic [15:0] RPC = 16'hFFFE;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [18:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready;
   logic [18:0] instr;
   logic [15:0] instr_pc;
   logic [4:0]  instr_opcode;
   logic        instr_is_ctrl;

   int checks = 0;
   int passes = 0;
   int xfers  = 0;

   logic [15:0] exp_q[$];
   logic [15:0] gen_pc;

   always #5 clk = ~clk;

   instr_fetch #(
      .DEPTH    (4),
      .RESET_PC (RPC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_opcode   (instr_opcode),
      .instr_is_ctrl  (instr_is_ctrl)
   );

   function automatic logic [18:0] mem_word(input logic [15:0] a);
      return {a[4:0] ^ a[12:8], a[13:0]};
   endfunction

   always @(posedge clk) begin
      imem_rvalid <= imem_req;
      imem_rdata  <= mem_word(imem_addr);
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp)
         passes++;
      else
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic top_up();
      while (exp_q.size() < 16) begin
         exp_q.push_back(gen_pc);
         gen_pc = gen_pc + 16'd1;
      end
   endtask

   task automatic restart(input logic [15:0] p);
      exp_q.delete();
      gen_pc = p;
      top_up();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      top_up();
   endtask

   // monitor: pops an expected address on every transfer
   logic        hold_prev = 1'b0;
   logic [15:0] hold_pc;
   logic [18:0] hold_instr;

   always @(negedge clk) begin
      logic [15:0] e;
      logic [18:0] w;
      logic [4:0]  opc;
      logic        ctl;
      if (!reset) begin
         if (hold_prev) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_pc", 32'(instr_pc), 32'(hold_pc));
            check("hold_instr", 32'(instr), 32'(hold_instr));
         end
         if (instr_valid && instr_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL sb_empty: got pc %0h, want none",
                        instr_pc);
            end else begin
               e   = exp_q.pop_front();
               w   = mem_word(e);
               opc = w[18:14];
               ctl = (opc >= 5'd10) && (opc <= 5'd14);
`ifndef IFETCH_PREDECODE_EN
               opc = 5'd0;
               ctl = 1'b0;
`endif
               check("xfer_pc", 32'(instr_pc), 32'(e));
               check("xfer_instr", 32'(instr), 32'(w));
               check("xfer_opcode", 32'(instr_opcode), 32'(opc));
               check("xfer_is_ctrl", 32'(instr_is_ctrl), 32'(ctl));
            end
         end
      end
      hold_prev  = !reset && !redirect_valid
                && instr_valid && !instr_ready;
      hold_pc    = instr_pc;
      hold_instr = instr;
   end

   initial begin
      int n;
      int x0;
      bit found;
      bit pend;
      logic [15:0] pend_pc;

      reset          = 1'b1;
      fetch_en       = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      restart(RPC);
      repeat (2) step();

      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'(RPC));
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_pc", 32'(instr_pc), 32'd0);
      check("rst_opcode", 32'(instr_opcode), 32'd0);
      check("rst_ctrl", 32'(instr_is_ctrl), 32'd0);

      // streaming latency, wrap from FFFE
      step();
      reset       = 1'b0;
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      check("lat_idle_req", 32'(imem_req), 32'd0);
      step();
      @(negedge clk);
      check("lat_req0", 32'(imem_req), 32'd1);
      check("lat_addr0", 32'(imem_addr), 32'(RPC));
      step();
      @(negedge clk);
      check("lat_valid_t1", 32'(instr_valid), 32'd0);
      check("lat_req1", 32'(imem_req), 32'd1);
      check("lat_addr1", 32'(imem_addr), 32'hFFFF);
      step();
      @(negedge clk);
      check("lat_valid_t2", 32'(instr_valid), 32'd1);
      check("lat_pc_t2", 32'(instr_pc), 32'(RPC));
      for (int i = 0; i < 6; i++) begin
         step();
         @(negedge clk);
         check("lat_stream", 32'(instr_valid), 32'd1);
      end

      // backpressure: exactly four requests
      step();
      reset       = 1'b1;
      instr_ready = 1'b0;
      step();
      reset = 1'b0;
      restart(RPC);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (imem_req) n++;
         step();
      end
      @(negedge clk);
      check("bp_reqs", 32'(n), 32'd4);
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_pc", 32'(instr_pc), 32'(RPC));
      step();
      instr_ready = 1'b1;

      // redirect while pc 7 response is in flight
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 16'h0007)
            found = 1'b1;
         else
            step();
      end
      check("rd_found_pc7", 32'(found), 32'd1);
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 16'h1234;
      step();
      redirect_valid = 1'b0;
      restart(16'h1234);
      @(negedge clk);
      check("rd_flush_valid", 32'(instr_valid), 32'd0);
      check("rd_flush_req", 32'(imem_req), 32'd0);
      step();
      @(negedge clk);
      check("rd_req", 32'(imem_req), 32'd1);
      check("rd_addr", 32'(imem_addr), 32'h1234);
      x0 = xfers;
      repeat (10) step();
      check("rd_progress", 32'(xfers - x0 >= 5), 32'd1);

      // fetch_en dropped after two requests
      reset       = 1'b1;
      instr_ready = 1'b0;
      fetch_en    = 1'b1;
      step();
      reset = 1'b0;
      restart(RPC);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (imem_req) n++;
         step();
         if (i == 2) fetch_en = 1'b0;
      end
      check("fe_reqs", 32'(n), 32'd2);
      x0 = xfers;
      instr_ready = 1'b1;
      repeat (6) step();
      @(negedge clk);
      check("fe_delivered", 32'(xfers - x0), 32'd2);
      check("fe_empty", 32'(instr_valid), 32'd0);
      check("fe_idle_req", 32'(imem_req), 32'd0);

      // random traffic
      x0   = xfers;
      pend = 1'b0;
      pend_pc = RPC;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (pend) restart(pend_pc);
         pend = 1'b0;
         reset          = ($urandom_range(0, 199) == 0);
         redirect_valid = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0)
            redirect_pc = 16'hFFF0 + 16'($urandom_range(0, 15));
         else
            redirect_pc = 16'($urandom);
         fetch_en    = ($urandom_range(0, 9) != 0);
         instr_ready = ($urandom_range(0, 3) != 0);
         if (reset) begin
            pend    = 1'b1;
            pend_pc = RPC;
         end else if (redirect_valid) begin
            pend    = 1'b1;
            pend_pc = redirect_pc;
         end
      end
      step();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      check("rand_progress", 32'(xfers - x0 > 300), 32'd1);
      repeat (4) step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
